// File: rtl/smac_pkg.sv
// Shared constants for the activation serial link (transmit shift register
// and receive demodulator).
//   PA_DEF : default word width / serial bits per word
//   cnt_w  : width of a modulo-pa bit counter
package smac_pkg;

   localparam int unsigned PA_DEF = 8;

   // Bit-counter width for a modulo-pa counter; never narrower than 1 bit.
   function automatic int unsigned cnt_w(input int unsigned pa);
      return (pa < 2) ? 1 : $clog2(pa);
   endfunction

endpackage

// File: rtl/smac_bit_cnt.sv
// Modulo-Pa serial bit counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one bit
//   cnt        : current bit count, 0..Pa-1
//   tc_c       : combinational terminal count, en on the last bit of a word
module smac_bit_cnt
   import smac_pkg::*;
#(
   parameter  int unsigned Pa = PA_DEF,
   localparam int unsigned CW = cnt_w(Pa)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc_c
);

   localparam logic [CW-1:0] LAST = CW'(Pa - 1);

   // Compare against Pa-1 so non-power-of-2 widths wrap correctly.
   assign tc_c = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/activ_demod_sr.sv
// Activation serial link receiver: collects an LSB-first bit stream into
// Pa-bit words and presents them on a one-entry valid/ready output buffer.
// The serial side cannot be stalled, so a word completing while the buffer
// is full is dropped and flagged on the sticky ovf.
//   clk, rst_n : clock, async active-low reset
//   cl_en      : synchronous clear, same effect as reset
//   s_en       : serial strobe, in_ser sampled when high
//   in_ser     : serial data, LSB first
//   out_par    : buffered parallel word
//   out_valid  : out_par holds an unconsumed word
//   out_ready  : consumer takes out_par when out_valid is high
//   busy       : partial word in progress (combinational)
//   ovf        : sticky overflow flag
module activ_demod_sr
   import smac_pkg::*;
#(
   parameter int unsigned Pa = PA_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cl_en,
   input  logic          s_en,
   input  logic          in_ser,
   output logic [Pa-1:0] out_par,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          ovf
);

   localparam int unsigned CW = cnt_w(Pa);

   // Only the upper Pa-1 bits of the shift register are kept: bit 0 would
   // just fall off on the next strobe and is never needed.
   logic [Pa-2:0] shreg;
   logic [Pa-1:0] word_c;
   logic [CW-1:0] cnt;
   logic          done_c;

   assign word_c = {in_ser, shreg};
   assign busy   = (cnt != '0);

   smac_bit_cnt #(.Pa(Pa)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cl_en),
      .en    (s_en),
      .cnt   (cnt),
      .tc_c  (done_c)
   );

   // Shift path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
      end else if (cl_en) begin
         shreg <= '0;
      end else if (s_en) begin
         shreg <= word_c[Pa-1:1];
      end
   end

   // Output buffer: completed word bypasses shreg straight into out_par.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_par   <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else if (cl_en) begin
         out_par   <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else if (done_c && (!out_valid || out_ready)) begin
         out_par   <= word_c;
         out_valid <= 1'b1;
      end else if (done_c) begin
         ovf       <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_activ_demod_sr.sv
module tb_activ_demod_sr;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cl_en = 1'b0;
   logic       s_en = 1'b0;
   logic       in_ser = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_par;
   logic       out_valid, busy, ovf;
   logic [4:0] out_par5;
   logic       out_valid5, busy5, ovf5;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] q8[$];
   logic [4:0] q5[$];
   bit         mon8_en = 1'b1;
   bit         mon5_en = 1'b0;

   typedef struct {
      logic [7:0]  word;
      int unsigned gap_max;
      int unsigned ready_lag;
      logic [7:0]  exp_par;
   } vec_t;

   vec_t vt[5];

   always #5 clk = ~clk;

   activ_demod_sr #(.Pa(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .cl_en(cl_en), .s_en(s_en), .in_ser(in_ser),
      .out_par(out_par), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .ovf(ovf)
   );

   activ_demod_sr #(.Pa(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .cl_en(cl_en), .s_en(s_en), .in_ser(in_ser),
      .out_par(out_par5), .out_valid(out_valid5), .out_ready(out_ready),
      .busy(busy5), .ovf(ovf5)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboards: compare every handshake transfer against the pushed word.
   always @(negedge clk) begin
      if (mon8_en && rst_n && !cl_en && out_valid && out_ready) begin
         if (q8.size() == 0) chk("xfer8_unexpected", 32'(out_par), 32'hFFFF_FFFF);
         else chk("xfer8", 32'(out_par), 32'(q8.pop_front()));
      end
      if (mon5_en && rst_n && !cl_en && out_valid5 && out_ready) begin
         if (q5.size() == 0) chk("xfer5_unexpected", 32'(out_par5), 32'hFFFF_FFFF);
         else chk("xfer5", 32'(out_par5), 32'(q5.pop_front()));
      end
   end

   task automatic send_word(input logic [7:0] w, input int unsigned width,
                            input int unsigned gap_max, input bit push8, input bit push5);
      for (int i = 0; i < int'(width); i++) begin
         int unsigned g;
         g = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
         repeat (g) begin
            s_en   = 1'b0;
            in_ser = 1'($urandom_range(1, 0));
            tick();
         end
         s_en   = 1'b1;
         in_ser = w[i];
         if (i == int'(width) - 1) begin
            if (push8) q8.push_back(w);
            if (push5) q5.push_back(w[4:0]);
         end
         tick();
      end
      s_en = 1'b0;
   endtask

   task automatic pulse_clear();
      cl_en = 1'b1;
      tick();
      cl_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] v;
      logic [7:0] act_sr;

      vt[0] = '{word: 8'hA5, gap_max: 0, ready_lag: 0, exp_par: 8'hA5};
      vt[1] = '{word: 8'hA5, gap_max: 3, ready_lag: 5, exp_par: 8'hA5};
      vt[2] = '{word: 8'hFF, gap_max: 1, ready_lag: 2, exp_par: 8'hFF};
      vt[3] = '{word: 8'h00, gap_max: 0, ready_lag: 0, exp_par: 8'h00};
      vt[4] = '{word: 8'h81, gap_max: 2, ready_lag: 1, exp_par: 8'h81};

      // Reset state
      repeat (2) tick();
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_par", 32'(out_par), 32'h0);
      chk("rst_ovf", 32'(ovf), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick();

      // Contiguous A5 with per-bit busy and one-cycle valid
      out_ready = 1'b1;
      v = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         chk("busy_pre_bit", 32'(busy), (i == 0) ? 32'h0 : 32'h1);
         s_en   = 1'b1;
         in_ser = v[i];
         if (i == 7) q8.push_back(v);
         tick();
         if (i < 7) chk("valid_midword", 32'(out_valid), 32'h0);
      end
      s_en = 1'b0;
      chk("a5_valid", 32'(out_valid), 32'h1);
      chk("a5_par", 32'(out_par), 32'hA5);
      chk("a5_busy_done", 32'(busy), 32'h0);
      tick();
      chk("a5_valid_one_cycle", 32'(out_valid), 32'h0);
      chk("a5_par_held", 32'(out_par), 32'hA5);

      // Table: gapped streams with delayed consumer
      for (int k = 0; k < 5; k++) begin
         out_ready = (vt[k].ready_lag == 0);
         send_word(vt[k].word, 8, vt[k].gap_max, 1'b1, 1'b0);
         chk("tbl_valid", 32'(out_valid), 32'h1);
         chk("tbl_par", 32'(out_par), 32'(vt[k].exp_par));
         for (int j = 0; j < int'(vt[k].ready_lag); j++) begin
            tick();
            chk("tbl_hold_valid", 32'(out_valid), 32'h1);
            chk("tbl_hold_par", 32'(out_par), 32'(vt[k].exp_par));
         end
         out_ready = 1'b1;
         tick();
         chk("tbl_consumed", 32'(out_valid), 32'h0);
         chk("tbl_ovf", 32'(ovf), 32'h0);
      end

      // Back-to-back: consume of 3C coincides with completion of C3
      out_ready = 1'b1;
      send_word(8'h3C, 8, 0, 1'b1, 1'b0);
      out_ready = 1'b0;
      v = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         s_en   = 1'b1;
         in_ser = v[i];
         if (i == 7) begin
            out_ready = 1'b1;
            q8.push_back(v);
         end
         tick();
         if (i < 7) begin
            chk("b2b_first_valid", 32'(out_valid), 32'h1);
            chk("b2b_first_par", 32'(out_par), 32'h3C);
         end
      end
      s_en = 1'b0;
      chk("b2b_valid_kept", 32'(out_valid), 32'h1);
      chk("b2b_par2", 32'(out_par), 32'hC3);
      chk("b2b_ovf", 32'(ovf), 32'h0);
      tick();
      chk("b2b_drained", 32'(out_valid), 32'h0);

      // Overflow: second word dropped while buffer full
      out_ready = 1'b0;
      send_word(8'h11, 8, 0, 1'b1, 1'b0);
      chk("ovf_before", 32'(ovf), 32'h0);
      send_word(8'h22, 8, 0, 1'b0, 1'b0);
      chk("ovf_par_old", 32'(out_par), 32'h11);
      chk("ovf_valid", 32'(out_valid), 32'h1);
      chk("ovf_set", 32'(ovf), 32'h1);
      tick();
      chk("ovf_sticky", 32'(ovf), 32'h1);
      pulse_clear();
      q8.delete();
      chk("clr_valid", 32'(out_valid), 32'h0);
      chk("clr_ovf", 32'(ovf), 32'h0);
      chk("clr_par", 32'(out_par), 32'h0);
      out_ready = 1'b1;

      // cl_en mid-word, with a strobe in the same cycle
      send_word(8'h03, 3, 0, 1'b0, 1'b0);
      chk("mid_busy", 32'(busy), 32'h1);
      s_en   = 1'b1;
      in_ser = 1'b1;
      cl_en  = 1'b1;
      tick();
      cl_en = 1'b0;
      s_en  = 1'b0;
      chk("mid_clr_busy", 32'(busy), 32'h0);
      chk("mid_clr_valid", 32'(out_valid), 32'h0);
      send_word(8'h5A, 8, 1, 1'b1, 1'b0);
      chk("clr_5a_par", 32'(out_par), 32'h5A);
      chk("clr_5a_valid", 32'(out_valid), 32'h1);
      tick();

      // Async reset mid-word
      send_word(8'h06, 3, 0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_valid", 32'(out_valid), 32'h0);
      chk("arst_par", 32'(out_par), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("arst_no_valid", 32'(out_valid), 32'h0);
      send_word(8'h5A, 8, 2, 1'b1, 1'b0);
      chk("arst_5a_par", 32'(out_par), 32'h5A);
      tick();

      // Loopback from a rotate-right activation shift register
      act_sr = 8'h96;
      for (int i = 0; i < 8; i++) begin
         s_en   = 1'b1;
         in_ser = act_sr[0];
         act_sr = {act_sr[0], act_sr[7:1]};
         if (i == 7) q8.push_back(8'h96);
         tick();
      end
      s_en = 1'b0;
      chk("loop_par", 32'(out_par), 32'h96);
      chk("loop_valid", 32'(out_valid), 32'h1);
      tick();

      // Pa=5 sweep
      mon8_en = 1'b0;
      pulse_clear();
      mon5_en = 1'b1;
      send_word(8'h13, 5, 1, 1'b0, 1'b1);
      chk("pa5_par", 32'(out_par5), 32'h13);
      chk("pa5_valid", 32'(out_valid5), 32'h1);
      chk("pa5_busy", 32'(busy5), 32'h0);
      tick();
      send_word(8'h0C, 5, 2, 1'b0, 1'b1);
      chk("pa5_par2", 32'(out_par5), 32'h0C);
      tick();
      chk("pa5_drained", 32'(out_valid5), 32'h0);
      mon5_en = 1'b0;
      pulse_clear();

      chk("q8_empty", 32'(q8.size()), 32'h0);
      chk("q5_empty", 32'(q5.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
